// File: rtl/fetch_seq_pkg.sv
// Shared types and helpers for the instruction-fetch sequencer.
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        HOLD,
        HALT
    } fetch_state_t;

    localparam logic [3:0] HALT_OP_DEF = 4'hF;

    // Extract the opcode field (top opc_w bits of an instr_w-bit word).
    function automatic logic [15:0] opc_field(input logic [63:0] instr,
                                              input int          instr_w,
                                              input int          opc_w);
        logic [63:0] mask;
        mask = (64'd1 << opc_w) - 64'd1;
        return 16'((instr >> (instr_w - opc_w)) & mask);
    endfunction

endpackage

// File: rtl/fetch_seq_if.sv
// Bus bundle between the fetch sequencer and its PC register, memory and decoder.
interface fetch_seq_if #(
    parameter int width   = 16,
    parameter int INSTR_W = 16
);
    logic               start;
    logic [width-1:0]   pc_in;
    logic               pc_inc_en;
    logic               pc_write_en;
    logic [width-1:0]   pc_dataIn;
    logic               imem_rd_en;
    logic [width-1:0]   imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic [INSTR_W-1:0] ir_out;
    logic               ir_valid;
    logic               ir_ready;
    logic               jump_req;
    logic [width-1:0]   jump_target;
    logic               halted;
    logic               busy;

    // Sequencer side.
    modport master (
        input  start, pc_in, imem_rdata, ir_ready, jump_req, jump_target,
        output pc_inc_en, pc_write_en, pc_dataIn, imem_rd_en, imem_addr,
               ir_out, ir_valid, halted, busy
    );

    // Environment side: PC register, instruction memory, decoder.
    modport slave (
        output start, pc_in, imem_rdata, ir_ready, jump_req, jump_target,
        input  pc_inc_en, pc_write_en, pc_dataIn, imem_rd_en, imem_addr,
               ir_out, ir_valid, halted, busy
    );
endinterface

// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: reads imem at the PC, latches the word into
// the IR, hands it to the decoder, steps/redirects the PC, stops on HALT.
module fetch_seq
    import fetch_pkg::*;
#(
    parameter int              width   = 16,
    parameter int              INSTR_W = 16,
    parameter int              OPC_W   = 4,
    parameter logic [OPC_W-1:0] HALT_OP = OPC_W'(HALT_OP_DEF)
) (
    input logic        clk,
    input logic        rst,
    fetch_seq_if.master bus
);

    fetch_state_t       state_q, state_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               inc_d, wr_d, rd_d;
    logic               is_halt;

    assign is_halt = (opc_field(64'(bus.imem_rdata), INSTR_W, OPC_W)
                      == 16'(HALT_OP));

    // State and instruction register; reset discards any pending word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Next-state and strobe decode.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        inc_d   = 1'b0;
        wr_d    = 1'b0;
        rd_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) state_d = FETCH;
            end
            FETCH: begin
                rd_d    = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                ir_d = bus.imem_rdata;
                if (is_halt) begin
                    state_d = HALT;
                end else begin
                    inc_d   = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.ir_ready) begin
                    wr_d    = bus.jump_req;
                    state_d = FETCH;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes are suppressed while rst is high so a reset landing in WAIT
    // or HOLD never moves the PC.
    assign bus.pc_inc_en   = inc_d & ~rst;
    assign bus.pc_write_en = wr_d & ~rst;
    assign bus.pc_dataIn   = bus.pc_write_en ? bus.jump_target : '0;
    assign bus.imem_rd_en  = rd_d & ~rst;
    assign bus.imem_addr   = bus.pc_in;
    assign bus.ir_out      = ir_q;
    assign bus.ir_valid    = (state_q == HOLD);
    assign bus.halted      = (state_q == HALT);
    assign bus.busy        = (state_q == FETCH) || (state_q == WAIT) ||
                             (state_q == HOLD);

endmodule

// File: doc/fetch_seq.md
Name: fetch_seq

Overview:
Instruction-fetch sequencer that sits directly upstream of the program-counter register (reginc) in each N-core.
- Drives the PC's inc_en/write_en/dataIn, reads instruction memory at the PC value, and latches the instruction word.
- Presents the latched word to the core decoder over a valid/ready handshake.
- Handles jump redirects and halts on the HALT opcode.

Parameters:
width, 16, PC/address width (matches reginc width)
INSTR_W, 16, instruction word width
OPC_W, 4, opcode field width (instruction bits [INSTR_W-1 -: OPC_W])
HALT_OP, 4'hF, opcode value that stops fetching

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  begin fetching from current PC (sampled in IDLE only)
pc_in  input  width  current PC (reginc dataOut)
pc_inc_en  output  1  one-cycle increment pulse to reginc
pc_write_en  output  1  one-cycle load pulse to reginc
pc_dataIn  output  width  load value to reginc (jump target)
imem_rd_en  output  1  instruction-memory read strobe
imem_addr  output  width  read address
imem_rdata  input  INSTR_W  read data, valid exactly 1 cycle after imem_rd_en
ir_out  output  INSTR_W  latched instruction
ir_valid  output  1  ir_out valid to decoder
ir_ready  input  1  decoder accepts ir_out
jump_req  input  1  redirect PC; honoured only in the handshake cycle
jump_target  input  width  redirect address
halted  output  1  HALT fetched, sequencer stopped
busy  output  1  high in any state except IDLE and HALT

Behaviour:
- Reset (rst=1 at posedge): state=IDLE. ir_out=0; ir_valid, pc_inc_en, pc_write_en, imem_rd_en, halted and busy all 0; pc_dataIn=0. Reset overrides any state, including mid-fetch and mid-handshake. A pending ir_out is discarded. The PC itself is reset by reginc, not by this block.
- FSM states: IDLE, FETCH, WAIT, HOLD, HALT.
- IDLE: outputs idle. start=1 moves to FETCH.
- FETCH: imem_rd_en=1 and imem_addr=pc_in (combinational from pc_in). Always moves to WAIT.
- WAIT: imem_rdata is valid; register it into ir_out.
  - If opcode==HALT_OP: go to HALT, no PC increment, ir_valid stays 0.
  - Otherwise: pulse pc_inc_en=1 for this cycle only and go to HOLD. pc_in therefore shows PC+1 from the first HOLD cycle.
- HOLD: ir_valid=1 and ir_out is stable until the handshake (ir_valid && ir_ready).
  - Handshake with jump_req=1: pc_write_en=1 and pc_dataIn=jump_target for that cycle, then FETCH. The next fetch reads jump_target.
  - Handshake with jump_req=0: go to FETCH.
  - jump_req without ir_ready is ignored.
  - ir_valid drops the cycle after the handshake.
- HALT: halted=1, busy=0. start, ir_ready and jump_req are ignored. Only rst exits.
- pc_inc_en and pc_write_en are never asserted in the same cycle, so reginc priority is never exercised.
- Throughput: 3 cycles per instruction when ir_ready is held high. Latency from start to ir_valid is 3 cycles.
- PC wrap-around (0xFFFF+1 -> 0) is done by reginc; fetch continues at 0 with no special handling.
- imem_addr is don't-care when imem_rd_en=0; drive pc_in.

Decomposition:
- Shared package fetch_pkg holds:
  - state enum fetch_state_t {IDLE, FETCH, WAIT, HOLD, HALT};
  - HALT_OP default;
  - the opcode-field extraction function.
- No sub-module: a single FSM plus the IR register.
- The testbench instantiates fetch_seq together with reginc and a 1-cycle-latency memory model.

Test Plan:
- Sequential fetch: PC reset to 0; mem[0]=16'h1234, mem[1]=16'h2345, mem[2]=16'hF000; start=1, ir_ready=1.
  -> ir_out shows 0x1234 then 0x2345, one handshake every 3 cycles.
  -> HALT reached after the fetch at address 2, halted=1, PC=2.
- Backpressure: ir_ready=0 for 5 cycles after first ir_valid.
  -> ir_out holds 0x1234 and ir_valid stays 1; imem_rd_en stays 0; PC stays 1 and is not re-incremented.
- Jump: at the handshake of instruction 0x1234, jump_req=1 with jump_target=16'h0010; mem[16]=16'h5555.
  -> pc_write_en pulses one cycle with pc_dataIn=0x0010.
  -> next imem_addr=0x0010 and ir_out=0x5555.
  -> jump_req=1 asserted while ir_ready=0 causes no pc_write_en.
- Reset mid-operation: assert rst in WAIT and again in HOLD.
  -> next cycle state=IDLE, ir_valid=0, busy=0, ir_out=0; no pc_inc_en pulse is emitted.
- Wrap: PC loaded to 0xFFFF with mem[0xFFFF]=16'h0001.
  -> after the handshake, imem_addr=0x0000.
- HALT stickiness: after halted=1, toggle start, ir_ready and jump_req.
  -> no imem_rd_en, pc_inc_en or pc_write_en; halted stays 1 until rst.
